// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, NOP word, reset PC and fetch FSM encoding.
package mips_pkg;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    FS_REQ     = 2'd0,
    FS_WAIT    = 2'd1,
    FS_HOLD    = 2'd2,
    FS_DISCARD = 2'd3
  } fetch_state_e;

  // Sequential next-PC; wraps modulo 2^32 and ignores alignment.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush > load > hold > NOP bubble.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        hold,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;

  always_comb begin
    id_instr_d = NOP_WORD;
    id_pc4_d   = id_pc4_q;
    id_valid_d = 1'b0;
    if (flush) begin
      id_instr_d = NOP_WORD;
      id_valid_d = 1'b0;
    end else if (load) begin
      id_instr_d = load_instr;
      id_pc4_d   = load_pc4;
      id_valid_d = 1'b1;
    end else if (hold) begin
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_instr_q <= NOP_WORD;
      id_pc4_q   <= 32'h0;
      id_valid_q <= 1'b0;
    end else begin
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign id_instr = id_instr_q;
  assign id_pc4   = id_pc4_q;
  assign id_valid = id_valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request, one-entry hold buffer
// for stalled responses, and branch redirect that squashes in-flight data.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic [5:0]  opcode
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_buf_q, hold_buf_d;
  logic         id_load;
  logic [31:0]  id_load_instr;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_buf_d    = hold_buf_q;
    id_load       = 1'b0;
    id_load_instr = hold_buf_q;
    case (state_q)
      FS_REQ: state_d = branch_taken ? FS_DISCARD : FS_WAIT;
      FS_WAIT: begin
        if (branch_taken) begin
          // Data arriving with the branch is already stale; otherwise squash it later.
          state_d = imem_valid ? FS_REQ : FS_DISCARD;
        end else if (imem_valid && !stall) begin
          id_load       = 1'b1;
          id_load_instr = imem_rdata;
          pc_d          = pc_plus4(pc_q);
          state_d       = FS_REQ;
        end else if (imem_valid) begin
          hold_buf_d = imem_rdata;
          state_d    = FS_HOLD;
        end
      end
      FS_HOLD: begin
        if (branch_taken) begin
          hold_buf_d = NOP_WORD;
          state_d    = FS_REQ;
        end else if (!stall) begin
          id_load    = 1'b1;
          pc_d       = pc_plus4(pc_q);
          hold_buf_d = NOP_WORD;
          state_d    = FS_REQ;
        end
      end
      FS_DISCARD: if (imem_valid) state_d = FS_REQ;
      default:    state_d = FS_REQ;
    endcase
    if (branch_taken) pc_d = branch_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_REQ;
      pc_q       <= RESET_PC;
      hold_buf_q <= NOP_WORD;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_buf_q <= hold_buf_d;
    end
  end

  // Gated by rst so the strobe stays low during reset and rises right after it.
  assign imem_req  = (state_q == FS_REQ) && !rst;
  assign imem_addr = pc_q;

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush      (branch_taken),
    .load       (id_load),
    .hold       (stall),
    .load_instr (id_load_instr),
    .load_pc4   (pc_plus4(pc_q)),
    .id_instr   (id_instr),
    .id_pc4     (id_pc4),
    .id_valid   (id_valid)
  );

  assign opcode = id_instr[31:26];

endmodule
